// File: rtl/btn_group_mask_ctrl.sv
// Synchronizes buttons/switches, debounces buttons into press strobes and a 4-bit group blank mask, and drives LEDs.
// Latency: sw->led SYNC_STAGES+1, btn->blank SYNC_STAGES+DEBOUNCE_CYCLES+1, blank->led 1; no backpressure, no comb in->out path.
module btn_group_mask_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  btn,
  input  logic [15:0] sw,
  input  logic        mode,
  output logic [3:0]  blank,
  output logic [3:0]  btn_pulse,
  output logic [15:0] led
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][20:0] r_sync;
  logic [20:0]                  w_in;
  logic [3:0]                   w_btn_s;
  logic [15:0]                  w_sw_s;
  logic                         w_mode_s;

  logic [CW-1:0] r_cnt [4];
  logic [3:0]    r_db;
  logic [3:0]    r_db_d;
  logic [3:0]    w_rise;
  logic [3:0]    r_blank;
  logic [3:0]    r_pulse;
  logic [15:0]   r_led;

  assign w_in                      = {mode, sw, btn};
  assign {w_mode_s, w_sw_s, w_btn_s} = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= w_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  // Counter clears whenever the input agrees with the stable state, so any glitch restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
      r_db   <= '0;
      r_db_d <= '0;
    end else begin
      r_db_d <= r_db;
      for (int i = 0; i < 4; i++) begin
        if (w_btn_s[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_cnt[i] <= '0;
          r_db[i]  <= w_btn_s[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign w_rise = r_db & ~r_db_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pulse <= '0;
      r_blank <= '0;
      r_led   <= '0;
    end else begin
      r_pulse <= w_rise;
      r_blank <= w_mode_s ? r_db : (r_blank ^ w_rise);
      for (int g = 0; g < 4; g++) begin
        r_led[4*g +: 4] <= r_blank[g] ? 4'h0 : w_sw_s[4*g +: 4];
      end
    end
  end

  assign blank     = r_blank;
  assign btn_pulse = r_pulse;
  assign led       = r_led;

endmodule

// File: tb/tb_btn_group_mask_ctrl.sv
// Directed bench for btn_group_mask_ctrl with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Expected outputs are queued with their due cycle when stimulus is driven and checked as the cycle arrives.
module tb_btn_group_mask_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  btn;
  logic [15:0] sw;
  logic        mode;
  logic [3:0]  blank;
  logic [3:0]  btn_pulse;
  logic [15:0] led;

  btn_group_mask_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .sw       (sw),
    .mode     (mode),
    .blank    (blank),
    .btn_pulse(btn_pulse),
    .led      (led)
  );

  typedef struct {
    string       tag;
    int          cyc;
    logic [2:0]  what;   // bit0 led, bit1 blank, bit2 btn_pulse
    logic [15:0] led;
    logic [3:0]  blank;
    logic [3:0]  pulse;
  } exp_t;

  exp_t q[$];
  int   cycle;
  int   vectors;
  int   errors;
  int   pulse_cnt [4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", q.size());
    $fatal(1, "watchdog");
  end

  // Count accepted presses per button, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (btn_pulse[i] === 1'b1) pulse_cnt[i]++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cycle++;
    end
  endtask

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic expect_at(input string tag, input int dt, input logic [2:0] what,
                           input logic [15:0] l, input logic [3:0] b, input logic [3:0] p);
    exp_t e;
    e.tag = tag; e.cyc = cycle + dt; e.what = what;
    e.led = l; e.blank = b; e.pulse = p;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    int   guard;
    guard = 0;
    while (q.size() > 0) begin
      if (q[0].cyc <= cycle) begin
        e = q.pop_front();
        if (e.what[0]) cmp({e.tag, ".led"},   led,               e.led);
        if (e.what[1]) cmp({e.tag, ".blank"}, {12'h0, blank},     {12'h0, e.blank});
        if (e.what[2]) cmp({e.tag, ".pulse"}, {12'h0, btn_pulse}, {12'h0, e.pulse});
      end else if (guard > 1000) begin
        vectors++;
        errors++;
        $display("FAIL drain_timeout: observed cycle %0d expected entry %s by cycle %0d", cycle, q[0].tag, q[0].cyc);
        q.delete();
      end else begin
        tick(1);
        guard++;
      end
    end
  endtask

  initial begin
    cycle = 0; vectors = 0; errors = 0;
    for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;

    // Reset with everything driven high
    rst_n = 1'b0; sw = 16'hFFFF; btn = 4'hF; mode = 1'b0;
    tick(1);
    expect_at("rst", 3, 3'b111, 16'h0000, 4'h0, 4'h0);
    drain();

    // Switch path
    sw = 16'h0000; btn = 4'h0;
    rst_n = 1'b1;
    tick(5);
    sw = 16'hA5C3;
    expect_at("sw_early", 2, 3'b011, 16'h0000, 4'h0, 4'h0);
    expect_at("sw_led",   3, 3'b011, 16'hA5C3, 4'h0, 4'h0);
    drain();

    // Clean press on btn[1], toggle mode
    btn = 4'b0010;
    expect_at("p1_quiet", 6, 3'b110, 16'h0000, 4'h0, 4'h0);
    expect_at("p1_hit",   7, 3'b111, 16'hA5C3, 4'b0010, 4'b0010);
    expect_at("p1_led",   8, 3'b111, 16'hA503, 4'b0010, 4'h0);
    drain();
    btn = 4'b0000;
    tick(10);
    cmp("p1_release_blank", {12'h0, blank}, 16'h0002);
    cmp("p1_pulse_count", 16'(pulse_cnt[1]), 16'd1);
    btn = 4'b0010;
    expect_at("p1b_hit", 7, 3'b110, 16'h0000, 4'b0000, 4'b0010);
    expect_at("p1b_led", 8, 3'b111, 16'hA5C3, 4'b0000, 4'h0);
    drain();
    btn = 4'b0000;
    tick(10);

    // Bounce rejection on btn[2]: 3 high, 2 low, 3 high, 2 low
    btn = 4'b0100; tick(3);
    btn = 4'b0000; tick(2);
    btn = 4'b0100; tick(3);
    btn = 4'b0000; tick(2);
    tick(6);
    cmp("bounce_pulse_count", 16'(pulse_cnt[2]), 16'd0);
    cmp("bounce_blank", {12'h0, blank}, 16'h0000);
    btn = 4'b0100;
    expect_at("b2_quiet", 6, 3'b110, 16'h0000, 4'h0, 4'h0);
    expect_at("b2_hit",   7, 3'b110, 16'h0000, 4'b0100, 4'b0100);
    expect_at("b2_led",   8, 3'b111, 16'hA0C3, 4'b0100, 4'h0);
    drain();
    cmp("b2_pulse_count", 16'(pulse_cnt[2]), 16'd1);
    btn = 4'b0000;
    tick(10);

    // Momentary mode: blank follows debounced buttons
    mode = 1'b1; btn = 4'b1001;
    expect_at("m_follow_db", 3, 3'b110, 16'h0000, 4'b0000, 4'h0);
    expect_at("m_press",     7, 3'b110, 16'h0000, 4'b1001, 4'b1001);
    expect_at("m_led",       8, 3'b111, 16'h05C0, 4'b1001, 4'h0);
    drain();
    tick(5);
    cmp("m_held_blank", {12'h0, blank}, 16'h0009);
    btn = 4'b0000;
    expect_at("m_rel_wait", 6, 3'b010, 16'h0000, 4'b1001, 4'h0);
    expect_at("m_rel",      7, 3'b110, 16'h0000, 4'b0000, 4'h0);
    expect_at("m_rel_led",  8, 3'b111, 16'hA5C3, 4'b0000, 4'h0);
    drain();
    cmp("m_pulse_count0", 16'(pulse_cnt[0]), 16'd1);
    cmp("m_pulse_count3", 16'(pulse_cnt[3]), 16'd1);

    // Simultaneous presses, toggle mode, then held
    mode = 1'b0; btn = 4'hF;
    expect_at("all_hit", 7, 3'b110, 16'h0000, 4'hF, 4'hF);
    expect_at("all_led", 8, 3'b111, 16'h0000, 4'hF, 4'h0);
    drain();
    tick(20);
    cmp("held_blank", {12'h0, blank}, 16'h000F);
    cmp("held_cnt0", 16'(pulse_cnt[0]), 16'd2);
    cmp("held_cnt1", 16'(pulse_cnt[1]), 16'd3);
    cmp("held_cnt2", 16'(pulse_cnt[2]), 16'd2);
    cmp("held_cnt3", 16'(pulse_cnt[3]), 16'd2);

    // Asynchronous reset mid-cycle clears outputs before the next edge
    #2;
    rst_n = 1'b0;
    #1;
    cmp("arst_blank", {12'h0, blank},     16'h0000);
    cmp("arst_pulse", {12'h0, btn_pulse}, 16'h0000);
    cmp("arst_led",   led,                16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
